// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: accepts a length-prefixed byte stream, assembles
// big-endian 32-bit words and writes them from address 0 while holding the core in reset.
module instr_mem_loader #(
    parameter int Ins_mem_width = 32,
    parameter int Ins_mem_depth = 256,
    parameter int pc_width      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     wr_en_ins,
    output logic [pc_width-1:0]      wr_add_ins,
    output logic [Ins_mem_width-1:0] wr_data_ins,
    output logic                     cpu_rst_n,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(Ins_mem_depth);

    state_t      state_r;
    state_t      nxt_s;
    logic [15:0] count_r;
    logic [15:0] word_idx_r;
    logic [1:0]  byte_cnt_r;
    logic [23:0] word_r;
    logic        xfer_s;
    logic [15:0] hdr_count_s;

    assign xfer_s      = byte_valid && byte_ready;
    assign hdr_count_s = {count_r[15:8], byte_in};

    // Next-state selection; a rejected count goes to ERR before any write is issued.
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) nxt_s = HDR_HI;
                else       nxt_s = IDLE;
            end
            HDR_HI: begin
                if (xfer_s) nxt_s = HDR_LO;
                else        nxt_s = HDR_HI;
            end
            HDR_LO: begin
                if (!xfer_s)                     nxt_s = HDR_LO;
                else if (hdr_count_s == 16'd0)   nxt_s = DONE;
                else if (hdr_count_s > DEPTH16)  nxt_s = ERR;
                else                             nxt_s = DATA;
            end
            DATA: begin
                if (xfer_s && (byte_cnt_r == 2'd3)) nxt_s = WRITE;
                else                                nxt_s = DATA;
            end
            WRITE: begin
                if ((word_idx_r + 16'd1) == count_r) nxt_s = DONE;
                else                                 nxt_s = DATA;
            end
            DONE, ERR: begin
                if (start) nxt_s = HDR_HI;
                else       nxt_s = state_r;
            end
            default: nxt_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs; status outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            count_r     <= 16'd0;
            word_idx_r  <= 16'd0;
            byte_cnt_r  <= 2'd0;
            word_r      <= 24'd0;
            byte_ready  <= 1'b0;
            wr_en_ins   <= 1'b0;
            wr_add_ins  <= {pc_width{1'b0}};
            wr_data_ins <= {Ins_mem_width{1'b0}};
            cpu_rst_n   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r    <= nxt_s;
            byte_ready <= (nxt_s == HDR_HI) || (nxt_s == HDR_LO) || (nxt_s == DATA);
            busy       <= (nxt_s == HDR_HI) || (nxt_s == HDR_LO) || (nxt_s == DATA) || (nxt_s == WRITE);
            done       <= (nxt_s == DONE);
            err        <= (nxt_s == ERR);
            cpu_rst_n  <= (nxt_s == DONE);
            wr_en_ins  <= (nxt_s == WRITE);
            if (xfer_s) begin
                case (state_r)
                    HDR_HI: count_r[15:8] <= byte_in;
                    HDR_LO: begin
                        count_r[7:0] <= byte_in;
                        word_idx_r   <= 16'd0;
                        byte_cnt_r   <= 2'd0;
                    end
                    DATA: begin
                        word_r     <= {word_r[15:0], byte_in};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            wr_add_ins  <= pc_width'({word_idx_r, 2'b00});
                            wr_data_ins <= Ins_mem_width'({word_r, byte_in});
                        end
                    end
                    default: ;
                endcase
            end
            if (state_r == WRITE) begin
                word_idx_r <= word_idx_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: random program words checked against
// an expected write list computed from the frame contents.
module tb_instr_mem_loader;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, wr_en_ins, cpu_rst_n, busy, done, err;
    logic [31:0] wr_add_ins, wr_data_ins;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] words[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int ready_in_write = 0;
    int long_write = 0;
    int last_wr_cyc = 0;
    logic prev_wr = 1'b0;

    instr_mem_loader #(.Ins_mem_width(32), .Ins_mem_depth(DEPTH), .pc_width(32)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wr_en_ins(wr_en_ins), .wr_add_ins(wr_add_ins),
        .wr_data_ins(wr_data_ins), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: capture every strobe cycle away from the active edge.
    always @(negedge clk) begin
        if (wr_en_ins) begin
            cap_addr.push_back(wr_add_ins);
            cap_data.push_back(wr_data_ins);
            last_wr_cyc <= cyc;
            if (byte_ready) ready_in_write <= ready_in_write + 1;
            if (prev_wr) long_write <= long_write + 1;
        end
        prev_wr <= wr_en_ins;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        @(negedge clk);
        cap_addr.delete();
        cap_data.delete();
        ready_in_write = 0;
        long_write = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        logic took;
        int   t;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
        end
        took = 1'b0;
        t = 0;
        while (!took && t < 20) begin
            @(negedge clk);
            start = st;
            byte_valid = 1'b1;
            byte_in = b;
            took = byte_ready;
            t++;
            @(posedge clk);
        end
        if (!took) chk("byte_accept_timeout", took, 1'b1);
    endtask

    task automatic wait_end(output int end_cyc);
        int t;
        t = 0;
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
        while (!(done || err) && t < 40) begin
            @(negedge clk);
            t++;
        end
        end_cyc = cyc;
        chk("end_timeout", (t < 40), 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, byte_ready, 1'b0);
        chk({tag, "_wr_en"}, wr_en_ins, 1'b0);
        chk({tag, "_wr_add"}, wr_add_ins, 32'd0);
        chk({tag, "_wr_data"}, wr_data_ins, 32'd0);
        chk({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    // mode 0: valid held high; 1: valid toggling plus a random gap before byte 3; 2: start held during data
    task automatic load(input logic [15:0] n, input int mode, input string tag);
        bit   exp_err;
        int   nbytes, gap, end_cyc;
        logic [7:0] b;
        exp_err = (n > DEPTH);
        clear_capture();
        pulse_start();
        chk({tag, "_busy_after_start"}, busy, 1'b1);
        send_byte(n[15:8], 0, 1'b0);
        send_byte(n[7:0], 0, 1'b0);
        nbytes = exp_err ? 0 : 4 * int'(n);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'(words[i / 4] >> (8 * (3 - (i % 4))));
            gap = 0;
            if (mode == 1) gap = (i == 2) ? int'($urandom_range(2, 9)) : 1;
            send_byte(b, gap, (mode == 2) && (i < nbytes - 1));
        end
        wait_end(end_cyc);
        chk({tag, "_done"}, done, !exp_err);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_cpu_rst_n"}, cpu_rst_n, !exp_err);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_wr_en_idle"}, wr_en_ins, 1'b0);
        chk({tag, "_nwrites"}, cap_addr.size(), exp_err ? 0 : int'(n));
        for (int i = 0; i < cap_addr.size() && i < nbytes / 4; i++) begin
            chk({tag, "_addr"}, cap_addr[i], 32'(i * 4));
            chk({tag, "_data"}, cap_data[i], words[i]);
        end
        chk({tag, "_ready_in_write"}, ready_in_write, 0);
        chk({tag, "_write_len"}, long_write, 0);
        if (!exp_err && n != 16'd0) begin
            chk({tag, "_done_latency"}, end_cyc, last_wr_cyc + 1);
            chk({tag, "_addr_hold"}, wr_add_ins, 32'((int'(n) - 1) * 4));
        end
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        int c;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // fixed example program
        words.delete();
        words.push_back(32'h20080005);
        words.push_back(32'h20090003);
        load(16'd2, 0, "t1");

        words.delete();
        load(16'd0, 0, "t2_empty");

        rand_words(0);
        load(16'd257, 0, "t3_over");
        rand_words(DEPTH);
        load(16'(DEPTH), 0, "t3_full");

        rand_words(1);
        load(16'd1, 1, "t4_stall");
        rand_words(3);
        load(16'd3, 1, "t4_stall3");

        // reset after six data bytes: one word written, partial word dropped
        rand_words(3);
        clear_capture();
        pulse_start();
        send_byte(8'd0, 0, 1'b0);
        send_byte(8'd3, 0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'(words[i / 4] >> (8 * (3 - (i % 4)))), 0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        chk("t5_nwrites", cap_addr.size(), 1);
        if (cap_addr.size() > 0) chk("t5_data0", cap_data[0], words[0]);
        @(negedge clk);
        rst = 1'b1;
        rand_words(3);
        load(16'd3, 0, "t5_reload");

        rand_words(2);
        load(16'd2, 2, "t6_start_ignored");
        rand_words(5);
        load(16'd5, 2, "t6_start5");

        for (int k = 0; k < 3; k++) begin
            c = int'($urandom_range(1, 12));
            rand_words(c);
            load(16'(c), int'($urandom_range(0, 2)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
